// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder word-memory responder.
// The optional byte-strobe build is selected with MEM_RESPONDER_WSTRB_EN.
package mem_responder_pkg;

    localparam int MEM_RESP_MAX_LATENCY = 15;

    typedef enum logic [1:0] {
        MEM_RESP_IDLE = 2'd0,
        MEM_RESP_BUSY = 2'd1,
        MEM_RESP_RESP = 2'd2
    } mem_resp_state_t;

    // Full 32-bit compare: high address bits never alias back into range.
    function automatic logic addr_out_of_range(input logic [31:0] addr,
                                               input int unsigned depth);
        return (addr >= depth);
    endfunction

    // Counter load value; out-of-range latencies are clamped to 1..15.
    function automatic logic [3:0] latency_load(input int latency);
        if (latency < 1)
            return 4'd1;
        if (latency > MEM_RESP_MAX_LATENCY)
            return 4'(MEM_RESP_MAX_LATENCY);
        return 4'(latency);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response channel bundle between a CPU memory controller and mem_responder.
// req_wstrb exists only when MEM_RESPONDER_WSTRB_EN is defined.
interface mem_responder_if #(
    parameter int width = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [31:0]       req_addr;
    logic [width-1:0]  req_wdata;
`ifdef MEM_RESPONDER_WSTRB_EN
    logic [width/8-1:0] req_wstrb;
`endif
    logic              resp_valid;
    logic              resp_ready;
    logic [width-1:0]  resp_rdata;
    logic              resp_err;

    modport master (
`ifdef MEM_RESPONDER_WSTRB_EN
        output req_wstrb,
`endif
        output req_valid,
        output req_write,
        output req_addr,
        output req_wdata,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  resp_err
    );

    modport slave (
`ifdef MEM_RESPONDER_WSTRB_EN
        input  req_wstrb,
`endif
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output resp_err
    );

endinterface

// File: rtl/mem_resp_delay.sv
// 4-bit loadable down-counter timing the BUSY dwell of mem_responder.
// done flags the last dwell cycle (count of 1) or a zero-length load.
module mem_resp_delay (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_value,
    output logic       done
);

    logic [3:0] count_reg;
    logic [3:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (load)
            count_next = load_value;
        else if (count_reg != 4'd0)
            count_next = count_reg - 4'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count_reg <= 4'd0;
        else
            count_reg <= count_next;
    end

    assign done = (count_reg == 4'd1) || (load_value == 4'd0);

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency word memory responder: one request in flight, response after LATENCY cycles.
// Define MEM_RESPONDER_WSTRB_EN for byte-strobed writes; otherwise writes update full words.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int depth   = 2048,
    parameter int width   = 32,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);

    localparam int         AW   = (depth > 1) ? $clog2(depth) : 1;
    localparam int         NB   = width / 8;
    localparam logic [3:0] LOAD = latency_load(LATENCY);

    mem_resp_state_t   state_reg;
    mem_resp_state_t   state_next;

    logic              accept;
    logic              commit;
    logic              req_err;
    logic [AW-1:0]     req_idx;
    logic [AW-1:0]     rd_idx;
    logic [NB-1:0]     byte_en;

    logic              lat_write_reg;
    logic              lat_err_reg;
    logic [AW-1:0]     lat_idx_reg;

    logic [width-1:0]  mem [depth];
    logic [width-1:0]  rd_data_reg;

    logic [width-1:0]  resp_rdata_reg;
    logic              resp_err_reg;

    logic              cnt_load;
    logic              cnt_done;

    assign req_idx = bus.req_addr[AW-1:0];
    assign req_err = addr_out_of_range(bus.req_addr, depth);
    assign accept  = (state_reg == MEM_RESP_IDLE) && bus.req_valid;
    assign commit  = accept && bus.req_write && !req_err;

`ifdef MEM_RESPONDER_WSTRB_EN
    assign byte_en = bus.req_wstrb;
`else
    assign byte_en = '1;
`endif

    // The read port follows the live request while idle and the latched index
    // afterwards, so its registered output is valid from the cycle after acceptance.
    assign rd_idx = (state_reg == MEM_RESP_IDLE) ? req_idx : lat_idx_reg;

    mem_resp_delay u_delay (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .load_value (LOAD),
        .done       (cnt_done)
    );

    always_comb begin
        state_next = state_reg;
        cnt_load   = 1'b0;
        unique case (state_reg)
            MEM_RESP_IDLE: begin
                if (bus.req_valid) begin
                    cnt_load   = 1'b1;
                    state_next = MEM_RESP_BUSY;
                end
            end
            MEM_RESP_BUSY: begin
                if (cnt_done)
                    state_next = MEM_RESP_RESP;
            end
            MEM_RESP_RESP: begin
                if (bus.resp_ready)
                    state_next = MEM_RESP_IDLE;
            end
            default: state_next = MEM_RESP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_reg <= MEM_RESP_IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_write_reg <= 1'b0;
            lat_err_reg   <= 1'b0;
            lat_idx_reg   <= '0;
        end else if (accept) begin
            lat_write_reg <= bus.req_write;
            lat_err_reg   <= req_err;
            lat_idx_reg   <= req_idx;
        end
    end

    // Storage is deliberately outside the reset: a write committed on its
    // acceptance edge survives a later reset.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < NB; b++) begin
                if (byte_en[b])
                    mem[req_idx][b*8 +: 8] <= bus.req_wdata[b*8 +: 8];
            end
        end
        rd_data_reg <= mem[rd_idx];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_rdata_reg <= '0;
            resp_err_reg   <= 1'b0;
        end else if ((state_reg == MEM_RESP_BUSY) && cnt_done) begin
            resp_rdata_reg <= (lat_write_reg || lat_err_reg) ? '0 : rd_data_reg;
            resp_err_reg   <= lat_err_reg;
        end else if ((state_reg == MEM_RESP_RESP) && bus.resp_ready) begin
            resp_rdata_reg <= '0;
            resp_err_reg   <= 1'b0;
        end
    end

    assign bus.req_ready  = (state_reg == MEM_RESP_IDLE);
    assign bus.resp_valid = (state_reg == MEM_RESP_RESP);
    assign bus.resp_rdata = resp_rdata_reg;
    assign bus.resp_err   = resp_err_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (LATENCY = 2, depth = 2048).
// Byte-strobe vectors run only when MEM_RESPONDER_WSTRB_EN is defined.
module tb_mem_responder;

    localparam int LAT = 2;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mem_responder_if #(.width(32)) bus ();

    mem_responder #(
        .depth   (2048),
        .width   (32),
        .LATENCY (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One request; hold = cycles to keep resp_ready low after resp_valid.
    task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb, input int hold,
                          output logic [31:0] rdata, output logic err);
        int lat;
        @(negedge clk);
        check_val({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
`ifdef MEM_RESPONDER_WSTRB_EN
        bus.req_wstrb = strb;
`else
        if (strb != 4'hF)
            $display("note: %s strobe ignored in full-word build", tag);
`endif
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.resp_valid && lat < 40);
        check_val({tag, "_latency"}, 32'(lat), 32'(LAT));
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_val({tag, "_hold_valid"}, 32'(bus.resp_valid), 32'd1);
            check_val({tag, "_hold_rdata"}, bus.resp_rdata, rdata);
            check_val({tag, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        check_val({tag, "_done_valid"}, 32'(bus.resp_valid), 32'd0);
        check_val({tag, "_done_ready"}, 32'(bus.req_ready), 32'd1);
        check_val({tag, "_done_rdata"}, bus.resp_rdata, 32'd0);
        $display("txn %s: wr=%0d addr=0x%0h wdata=0x%0h -> rdata=0x%0h err=%0d lat=%0d",
                 tag, wr, addr, wdata, rdata, err, lat);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          seen;

        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;
`ifdef MEM_RESPONDER_WSTRB_EN
        bus.req_wstrb  = 4'hF;
`endif

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_hold_valid", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_ready", 32'(bus.req_ready), 32'd1);
        check_val("rst_valid", 32'(bus.resp_valid), 32'd0);
        check_val("rst_rdata", bus.resp_rdata, 32'd0);
        check_val("rst_err",   32'(bus.resp_err), 32'd0);

        // Write then read back
        do_req("wr5", 1'b1, 32'd5, 32'hDEADBEEF, 4'hF, 0, rd, er);
        check_val("wr5_rdata", rd, 32'd0);
        check_val("wr5_err", 32'(er), 32'd0);
        do_req("rd5", 1'b0, 32'd5, 32'h0, 4'hF, 0, rd, er);
        check_val("rd5_rdata", rd, 32'hDEADBEEF);
        check_val("rd5_err", 32'(er), 32'd0);

        // Backpressure
        do_req("bp5", 1'b0, 32'd5, 32'h0, 4'hF, 5, rd, er);
        check_val("bp5_rdata", rd, 32'hDEADBEEF);

        // Range boundaries; addr 2048 would alias index 0 if truncated
        do_req("wr0", 1'b1, 32'd0, 32'hCAFEF00D, 4'hF, 0, rd, er);
        do_req("wr2047", 1'b1, 32'd2047, 32'h12345678, 4'hF, 0, rd, er);
        check_val("wr2047_err", 32'(er), 32'd0);
        do_req("wr2048", 1'b1, 32'd2048, 32'h00000001, 4'hF, 0, rd, er);
        check_val("wr2048_err", 32'(er), 32'd1);
        check_val("wr2048_rdata", rd, 32'd0);
        do_req("rd0", 1'b0, 32'd0, 32'h0, 4'hF, 0, rd, er);
        check_val("rd0_rdata", rd, 32'hCAFEF00D);
        check_val("rd0_err", 32'(er), 32'd0);
        do_req("rd2047", 1'b0, 32'd2047, 32'h0, 4'hF, 0, rd, er);
        check_val("rd2047_rdata", rd, 32'h12345678);
        do_req("rdmax", 1'b0, 32'hFFFFFFFF, 32'h0, 4'hF, 0, rd, er);
        check_val("rdmax_err", 32'(er), 32'd1);
        check_val("rdmax_rdata", rd, 32'd0);

        // Reset during an in-flight read
        do_req("wr7", 1'b1, 32'd7, 32'h0BADC0DE, 4'hF, 0, rd, er);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'd7;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_val("mid_rst_ready", 32'(bus.req_ready), 32'd1);
        check_val("mid_rst_valid", 32'(bus.resp_valid), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (bus.resp_valid)
                seen++;
        end
        check_val("mid_rst_no_resp", 32'(seen), 32'd0);
        check_val("mid_rst_ready_after", 32'(bus.req_ready), 32'd1);
        do_req("rd7", 1'b0, 32'd7, 32'h0, 4'hF, 0, rd, er);
        check_val("rd7_rdata", rd, 32'h0BADC0DE);

`ifdef MEM_RESPONDER_WSTRB_EN
        do_req("wr3", 1'b1, 32'd3, 32'h11223344, 4'hF, 0, rd, er);
        do_req("wr3s", 1'b1, 32'd3, 32'hAABBCCDD, 4'b0101, 0, rd, er);
        do_req("rd3", 1'b0, 32'd3, 32'h0, 4'hF, 0, rd, er);
        check_val("rd3_rdata", rd, 32'h11BB33DD);
        do_req("wr3z", 1'b1, 32'd3, 32'hFFFFFFFF, 4'b0000, 0, rd, er);
        check_val("wr3z_err", 32'(er), 32'd0);
        do_req("rd3z", 1'b0, 32'd3, 32'h0, 4'hF, 0, rd, er);
        check_val("rd3z_rdata", rd, 32'h11BB33DD);
`else
        do_req("wr3", 1'b1, 32'd3, 32'h11223344, 4'hF, 0, rd, er);
        do_req("wr3b", 1'b1, 32'd3, 32'hAABBCCDD, 4'hF, 0, rd, er);
        do_req("rd3", 1'b0, 32'd3, 32'h0, 4'hF, 0, rd, er);
        check_val("rd3_rdata", rd, 32'hAABBCCDD);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
